ahb_led_pwm: RTL and testbench
==============================

AHB_LED_PWM -- requirements
Module: ahb_led_pwm

Interface
REQ-001 Parameter NUM_LED, default 8, number of LED channels (legal range 1..32) SHALL be supported.
REQ-002 Parameter PWM_W, default 8, PWM counter and duty width (legal range 4..16) SHALL be supported.
REQ-003 Parameter PRESCALE_W, default 16, prescaler width (legal range 1..24) SHALL be supported.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port HCLK, input, 1 bit: the only clock, with all flops on its rising edge.
REQ-006 Port HRESET, input, 1 bit: synchronous, active-high reset.
REQ-007 Port HSEL, input, 1 bit: slave select.
REQ-008 Port HREADY, input, 1 bit: bus ready.
REQ-009 Port HADDR, input, 32 bits: address.
REQ-010 Port HTRANS, input, 2 bits: transfer type.
REQ-011 Port HWRITE, input, 1 bit: write flag.
REQ-012 Port HSIZE, input, 3 bits: transfer size, ignored.
REQ-013 Port HWDATA, input, 32 bits: write data.
REQ-014 Port HRDATA, output, 32 bits: read data.
REQ-015 Port HREADYOUT, output, 1 bit: slave ready, tied to 1 (zero-wait slave).
REQ-016 Port LED, output, NUM_LED bits: LED drive, registered.

Function
REQ-017 Address phase SHALL be captured when HSEL & HREADY & HTRANS[1]; HADDR[9:2] and HWRITE are registered, and the data phase occurs in the next cycle.
REQ-018 Writes SHALL update the target register from HWDATA at the end of the data phase; all accesses are treated as 32-bit, since HSIZE is ignored.
REQ-019 Reads SHALL present HRDATA combinationally from the registered address during the data phase; a read issued directly after a write to the same register returns the new value.
REQ-020 Register map (byte offsets) SHALL be:
  - 0x000 CTRL: [0] EN; [1] SYNC_CLR, write-1 pulse that reads 0.
  - 0x004 PRESC[PRESCALE_W-1:0].
  - 0x008 CHEN[NUM_LED-1:0].
  - 0x00C BLINK_MASK[NUM_LED-1:0].
  - 0x010 BLINK_PER[15:0].
  - 0x014 STATUS (read-only): [PWM_W-1:0] pwm_cnt, [16] blink_phase.
  - 0x100+4*i DUTY_SHADOW[i][PWM_W-1:0], for i < NUM_LED.
REQ-021 Unmapped offsets and unused bits SHALL read 0; writes to them and to STATUS SHALL be ignored.
REQ-022 Prescaler SHALL count 0..PRESC and emit a one-cycle tick when the count equals PRESC, then return to 0; PRESC=0 gives a tick every cycle.
REQ-023 pwm_cnt SHALL increment on each tick and wrap from 2^PWM_W-1 to 0; the wrap event is the tick at which pwm_cnt equals 2^PWM_W-1.
REQ-024 Each channel SHALL hold an active duty register, loaded from DUTY_SHADOW[i] only on wrap or SYNC_CLR (glitch-free update).
REQ-025 blink_cnt (16-bit) SHALL increment on each wrap; when it equals BLINK_PER on a wrap it returns to 0 and blink_phase toggles; BLINK_PER=0 toggles blink_phase on every wrap.
REQ-026 pwm_on[i] SHALL be (pwm_cnt < active_duty[i]) | (active_duty[i] == all ones).
REQ-027 LED[i] SHALL register EN & CHEN[i] & pwm_on[i] & (~BLINK_MASK[i] | blink_phase), giving one cycle of latency from the counter state.
REQ-028 While EN=0, the prescaler, pwm_cnt, blink_cnt and blink_phase SHALL be held at 0; active duty SHALL track the shadow every cycle; LED SHALL be 0.
REQ-029 SYNC_CLR SHALL, in the cycle its write completes, zero the prescaler, pwm_cnt, blink_cnt and blink_phase, and load all active duties.
REQ-030 If SYNC_CLR and a wrap occur in the same cycle, SYNC_CLR SHALL take priority.
REQ-031 A PRESC write SHALL take effect from the next cycle; if the new PRESC is below the current prescaler count, the count wraps to 0 next cycle without a tick.
REQ-032 A DUTY_SHADOW write in the same cycle as a wrap SHALL load the newly written value into the active duty.

Reset
REQ-033 While HRESET=1 at a rising edge, all registers, counters, blink_phase and active duties SHALL become 0.
REQ-034 During reset, LED SHALL be 0, HRDATA SHALL be 0 and HREADYOUT SHALL be 1.
REQ-035 A reset asserted mid-transfer SHALL discard the pending data phase, with no register updated.

Verification
REQ-036 Reset test: after reset, read all mapped registers -> all read 0, LED=0x00.
REQ-037 Duty test: PRESC=0, DUTY[0]=0x40, CHEN=0x01, EN=1 -> LED[0] is high for 64 of every 256 cycles, period 256; DUTY=0xFF -> always on; DUTY=0 -> always off.
REQ-038 Glitch-free update: change DUTY[0] from 0x40 to 0xC0 mid-period -> the high time changes only after the next pwm_cnt wrap, with no partial-width pulse.
REQ-039 Blink test: PRESC=0, BLINK_PER=1, BLINK_MASK=0x01, DUTY[0]=0xFF -> LED[0] is on for 512 cycles, then off for 512 cycles, repeating; STATUS[16] toggles accordingly.
REQ-040 SYNC_CLR test: SYNC_CLR written when pwm_cnt=0xFF with a tick pending -> STATUS reads pwm_cnt=0 with no wrap side effects; SYNC_CLR wins, and the active duty equals the shadow.
REQ-041 Bus edges test: back-to-back write and read of PRESC=0x1234 -> read returns 0x1234; read of 0x018 -> 0; write to STATUS -> unchanged; HTRANS=IDLE with HSEL=1 -> no update.

Source files
------------

// File: rtl/ahb_led_pwm.sv
// ---------------------------------------------------------------------------
// ahb_led_pwm
//   AHB-Lite zero-wait slave driving NUM_LED PWM-dimmed, optionally blinking
//   LED channels. A shared prescaler advances a shared PWM counter. Each
//   channel compares the counter against its own active duty. The active
//   duty is reloaded from a bus-visible shadow register only at the PWM wrap
//   (or on SYNC_CLR), so a running period is never cut short. A slow blink
//   counter, advanced once per PWM period, gates the channels selected by
//   BLINK_MASK.
//
// Ports
//   HCLK       in   clock, all flops on its rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select
//   HREADY     in   bus ready
//   HADDR      in   [31:0] address, word offset taken from [9:2]
//   HTRANS     in   [1:0] transfer type, NONSEQ/SEQ start an access
//   HWRITE     in   write flag
//   HSIZE      in   [2:0] transfer size, ignored (all accesses are 32-bit)
//   HWDATA     in   [31:0] write data
//   HRDATA     out  [31:0] read data, combinational in the data phase
//   HREADYOUT  out  always 1
//   LED        out  [NUM_LED-1:0] registered LED drive
// ---------------------------------------------------------------------------
module ahb_led_pwm #(
  parameter int NUM_LED    = 8,
  parameter int PWM_W      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSEL,
  input  logic               HREADY,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic [NUM_LED-1:0] LED
);

  // Word offsets of the register map (byte offset / 4)
  localparam logic [7:0] W_CTRL       = 8'd0;
  localparam logic [7:0] W_PRESC      = 8'd1;
  localparam logic [7:0] W_CHEN       = 8'd2;
  localparam logic [7:0] W_BLINK_MASK = 8'd3;
  localparam logic [7:0] W_BLINK_PER  = 8'd4;
  localparam logic [7:0] W_STATUS     = 8'd5;
  localparam int         DUTY_BASE    = 64;   // byte offset 0x100
  localparam logic [PWM_W-1:0] PWM_MAX = {PWM_W{1'b1}};

  // Data-phase state
  logic                          dp_valid_r;
  logic                          dp_write_r;
  logic [7:0]                    dp_addr_r;

  // Configuration registers
  logic                          en_r;
  logic [PRESCALE_W-1:0]         presc_r;
  logic [NUM_LED-1:0]            chen_r;
  logic [NUM_LED-1:0]            blink_mask_r;
  logic [15:0]                   blink_per_r;
  logic [NUM_LED-1:0][PWM_W-1:0] duty_shadow_r;

  // Counters and per-channel state
  logic [PRESCALE_W-1:0]         presc_cnt_r;
  logic [PWM_W-1:0]              pwm_cnt_r;
  logic [15:0]                   blink_cnt_r;
  logic                          blink_phase_r;
  logic [NUM_LED-1:0][PWM_W-1:0] active_duty_r;
  logic [NUM_LED-1:0]            led_r;

  // Combinational helpers
  logic                          addr_phase_s;
  logic                          wr_en_s;
  logic                          sync_clr_s;
  logic                          tick_s;
  logic                          wrap_s;
  logic [NUM_LED-1:0]            duty_wr_s;
  logic [NUM_LED-1:0][PWM_W-1:0] duty_next_s;
  logic [NUM_LED-1:0]            pwm_on_s;
  logic [31:0]                   rdata_s;
  logic [31:0]                   duty_rd_s;
  logic                          unused_s;

  assign addr_phase_s = HSEL & HREADY & HTRANS[1];
  assign wr_en_s      = dp_valid_r & dp_write_r;
  assign sync_clr_s   = wr_en_s & (dp_addr_r == W_CTRL) & HWDATA[1];
  assign tick_s       = en_r & (presc_cnt_r == presc_r);
  assign wrap_s       = tick_s & (pwm_cnt_r == PWM_MAX);
  assign HREADYOUT    = 1'b1;
  assign LED          = led_r;
  assign unused_s     = ^{HSIZE, HADDR[31:10], HADDR[1:0], HTRANS[0], HWDATA};

  // Per-channel shadow write decode, next shadow value and PWM compare.
  // duty_next_s already holds a shadow value being written in this cycle, so a
  // write coinciding with a wrap lands directly in the active duty.
  always_comb begin
    duty_wr_s   = '0;
    duty_next_s = '0;
    pwm_on_s    = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      duty_wr_s[i]   = wr_en_s & (dp_addr_r == 8'(DUTY_BASE + i));
      duty_next_s[i] = duty_wr_s[i] ? HWDATA[PWM_W-1:0] : duty_shadow_r[i];
      pwm_on_s[i]    = (pwm_cnt_r < active_duty_r[i]) | (active_duty_r[i] == PWM_MAX);
    end
  end

  // Read mux from the registered data-phase address
  always_comb begin
    rdata_s   = 32'd0;
    duty_rd_s = 32'd0;
    for (int i = 0; i < NUM_LED; i++) begin
      duty_rd_s = duty_rd_s |
                  ((dp_addr_r == 8'(DUTY_BASE + i)) ? 32'(duty_shadow_r[i]) : 32'd0);
    end
    case (dp_addr_r)
      W_CTRL:       rdata_s = {31'd0, en_r};
      W_PRESC:      rdata_s = 32'(presc_r);
      W_CHEN:       rdata_s = 32'(chen_r);
      W_BLINK_MASK: rdata_s = 32'(blink_mask_r);
      W_BLINK_PER:  rdata_s = {16'd0, blink_per_r};
      W_STATUS:     rdata_s = 32'(pwm_cnt_r) | {15'd0, blink_phase_r, 16'd0};
      default:      rdata_s = duty_rd_s;
    endcase
    if (dp_valid_r & ~dp_write_r & ~HRESET) begin
      HRDATA = rdata_s;
    end else begin
      HRDATA = 32'd0;
    end
  end

  // Address-phase capture; a reset drops any pending data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_addr_r  <= 8'd0;
    end else begin
      dp_valid_r <= addr_phase_s;
      dp_write_r <= HWRITE;
      dp_addr_r  <= HADDR[9:2];
    end
  end

  // Configuration register writes at the end of the data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_r          <= 1'b0;
      presc_r       <= '0;
      chen_r        <= '0;
      blink_mask_r  <= '0;
      blink_per_r   <= 16'd0;
      duty_shadow_r <= '0;
    end else begin
      duty_shadow_r <= duty_next_s;
      if (wr_en_s) begin
        case (dp_addr_r)
          W_CTRL:       en_r         <= HWDATA[0];
          W_PRESC:      presc_r      <= HWDATA[PRESCALE_W-1:0];
          W_CHEN:       chen_r       <= HWDATA[NUM_LED-1:0];
          W_BLINK_MASK: blink_mask_r <= HWDATA[NUM_LED-1:0];
          W_BLINK_PER:  blink_per_r  <= HWDATA[15:0];
          default:      en_r         <= en_r;
        endcase
      end
    end
  end

  // Prescaler and PWM counter. A count above a freshly lowered PRESC
  // returns to 0 without producing a tick.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      presc_cnt_r <= '0;
      pwm_cnt_r   <= '0;
    end else if (!en_r || sync_clr_s) begin
      presc_cnt_r <= '0;
      pwm_cnt_r   <= '0;
    end else begin
      if (presc_cnt_r >= presc_r) begin
        presc_cnt_r <= '0;
      end else begin
        presc_cnt_r <= presc_cnt_r + PRESCALE_W'(1);
      end
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
      end
    end
  end

  // Blink counter, advanced once per PWM period; SYNC_CLR beats a wrap
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      blink_cnt_r   <= 16'd0;
      blink_phase_r <= 1'b0;
    end else if (!en_r || sync_clr_s) begin
      blink_cnt_r   <= 16'd0;
      blink_phase_r <= 1'b0;
    end else if (wrap_s) begin
      if (blink_cnt_r == blink_per_r) begin
        blink_cnt_r   <= 16'd0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + 16'd1;
      end
    end
  end

  // Active duties reload only at a period boundary (or continuously while
  // disabled); LED output register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      active_duty_r <= '0;
      led_r         <= '0;
    end else begin
      if (!en_r || sync_clr_s || wrap_s) begin
        active_duty_r <= duty_next_s;
      end
      led_r <= {NUM_LED{en_r}} & chen_r & pwm_on_s &
               (~blink_mask_r | {NUM_LED{blink_phase_r}});
    end
  end

endmodule

// File: tb/tb_ahb_led_pwm.sv
// ---------------------------------------------------------------------------
// tb_ahb_led_pwm
//   Directed bench for ahb_led_pwm. Expected read data is queued when a read
//   address phase is driven and compared in its data phase. LED[0] high/low
//   run lengths are recorded by a monitor and compared to computed widths.
// ---------------------------------------------------------------------------
module tb_ahb_led_pwm;

  localparam int NUM_LED    = 8;
  localparam int PWM_W      = 8;
  localparam int PRESCALE_W = 16;

  localparam logic [31:0] A_CTRL       = 32'h000;
  localparam logic [31:0] A_PRESC      = 32'h004;
  localparam logic [31:0] A_CHEN       = 32'h008;
  localparam logic [31:0] A_BLINK_MASK = 32'h00C;
  localparam logic [31:0] A_BLINK_PER  = 32'h010;
  localparam logic [31:0] A_STATUS     = 32'h014;
  localparam logic [31:0] A_DUTY0      = 32'h100;
  localparam logic [31:0] A_DUTY7      = 32'h11C;

  logic               HCLK = 1'b0;
  logic               HRESET;
  logic               HSEL;
  logic               HREADY;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HSIZE;
  logic [31:0]        HWDATA;
  logic [31:0]        HRDATA;
  logic               HREADYOUT;
  logic [NUM_LED-1:0] LED;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_dp    = 1'b0;
  logic        last_led = 1'b0;
  int          led_acc  = 0;
  int          hi_runs[$];
  int          lo_runs[$];
  int          run_hi   = 0;
  int          run_lo   = 0;
  int          found;
  logic        prev;

  always #5 HCLK = ~HCLK;

  ahb_led_pwm #(
    .NUM_LED   (NUM_LED),
    .PWM_W     (PWM_W),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HREADY   (HREADY),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .LED      (LED)
  );

  // LED[0] run-length monitor
  always @(negedge HCLK) begin
    if (HRESET) begin
      run_hi <= 0;
      run_lo <= 0;
    end else if (LED[0] === 1'b1) begin
      if (run_lo != 0) lo_runs.push_back(run_lo);
      run_lo <= 0;
      run_hi <= run_hi + 1;
    end else begin
      if (run_hi != 0) hi_runs.push_back(run_hi);
      run_hi <= 0;
      run_lo <= run_lo + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, sample at negedge, compare a pending read
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] e;
    string       t;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HWDATA = wdata;
    @(negedge HCLK);
    last_led = LED[0];
    if (LED[0] === 1'b1) led_acc++;
    if (rd_dp && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, HRDATA, e);
    end
    rd_dp = sel & trans[1] & ~wr & HREADY;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    step(1'b1, 2'b10, 1'b1, addr, 32'd0);
    step(1'b0, 2'b00, 1'b0, 32'd0, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step(1'b1, 2'b10, 1'b0, addr, 32'd0);
    step(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic clear_runs();
    hi_runs.delete();
    lo_runs.delete();
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HADDR = 32'd0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = 32'd0;

    // Reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_led", 32'(LED), 32'd0);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Reset during a write data phase discards the write
    step(1'b1, 2'b10, 1'b1, A_CHEN, 32'd0);
    HRESET = 1'b1;
    step(1'b0, 2'b00, 1'b0, 32'd0, 32'hFF);
    HRESET = 1'b0;
    rd(A_CHEN, 32'd0, "rst_discard");

    // All mapped registers read 0 after reset
    rd(A_CTRL, 32'd0, "rst_ctrl");
    rd(A_PRESC, 32'd0, "rst_presc");
    rd(A_BLINK_MASK, 32'd0, "rst_blink_mask");
    rd(A_BLINK_PER, 32'd0, "rst_blink_per");
    rd(A_STATUS, 32'd0, "rst_status");
    rd(A_DUTY0, 32'd0, "rst_duty0");
    rd(A_DUTY7, 32'd0, "rst_duty7");
    check("rst_led_after", 32'(LED), 32'd0);

    // Bus edge cases
    step(1'b1, 2'b10, 1'b1, A_PRESC, 32'd0);
    exp_q.push_back(32'h1234); tag_q.push_back("b2b_presc");
    step(1'b1, 2'b10, 1'b0, A_PRESC, 32'h1234);
    step(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    rd(32'h018, 32'd0, "unmapped_018");
    wr(A_STATUS, 32'hFFFF_FFFF);
    rd(A_STATUS, 32'd0, "status_ro");
    step(1'b1, 2'b00, 1'b1, A_CHEN, 32'd0);
    step(1'b0, 2'b00, 1'b0, 32'd0, 32'hFF);
    rd(A_CHEN, 32'd0, "idle_no_write");
    wr(A_PRESC, 32'hFFFF_ABCD);
    rd(A_PRESC, 32'h0000_ABCD, "presc_width");
    wr(A_CTRL, 32'h2);
    rd(A_CTRL, 32'd0, "syncclr_reads0");
    wr(32'h120, 32'hFF);
    rd(32'h120, 32'd0, "duty8_unmapped");
    wr(A_DUTY7, 32'h1A5);
    rd(A_DUTY7, 32'hA5, "duty7_width");
    wr(A_BLINK_PER, 32'h1234_5678);
    rd(A_BLINK_PER, 32'h5678, "blink_per_width");
    wr(A_BLINK_PER, 32'd0);
    wr(A_PRESC, 32'd0);

    // Duty 0x40: 64 high of every 256 cycles
    wr(A_DUTY0, 32'h40);
    wr(A_CHEN, 32'h1);
    wr(A_CTRL, 32'h3);
    clear_runs();
    rd(A_STATUS, 32'h1, "status_after_sync");
    rd(A_CTRL, 32'h1, "ctrl_en");
    led_acc = 0;
    idle(256);
    check("duty40_high_cnt", led_acc, 32'd64);
    idle(300);
    check("duty40_npulses", 32'(hi_runs.size() >= 2), 32'd1);
    check("duty40_pulse0", hi_runs[0], 32'd64);
    check("duty40_pulse1", hi_runs[1], 32'd64);
    check("duty40_low", lo_runs[1], 32'd192);

    // Duty 0xFF always on, duty 0 always off
    wr(A_DUTY0, 32'hFF);
    idle(300);
    led_acc = 0;
    idle(256);
    check("dutyFF_high_cnt", led_acc, 32'd256);
    wr(A_DUTY0, 32'h0);
    idle(300);
    led_acc = 0;
    idle(256);
    check("duty00_high_cnt", led_acc, 32'd0);

    // Glitch-free update 0x40 -> 0xC0 in the middle of a high pulse
    wr(A_DUTY0, 32'h40);
    idle(300);
    found = 0;
    for (int n = 0; n < 600 && found == 0; n++) begin
      prev = last_led;
      idle(1);
      if (!prev && last_led) found = 1;
    end
    check("glitch_rise_found", found, 32'd1);
    clear_runs();
    idle(10);
    wr(A_DUTY0, 32'hC0);
    idle(700);
    check("glitch_npulses", 32'(hi_runs.size() >= 2), 32'd1);
    check("glitch_pulse0", hi_runs[0], 32'd64);
    check("glitch_low0", lo_runs[0], 32'd192);
    check("glitch_pulse1", hi_runs[1], 32'd192);

    // SYNC_CLR landing on the wrap cycle (pwm_cnt=0xFF, tick pending)
    wr(A_CTRL, 32'h3);
    wr(A_DUTY0, 32'h20);
    idle(252);
    wr(A_CTRL, 32'h3);
    clear_runs();
    rd(A_STATUS, 32'h1, "syncclr_status");
    rd(A_DUTY0, 32'h20, "syncclr_shadow");
    idle(300);
    check("syncclr_pulse0", hi_runs[0], 32'd32);

    // Blink: BLINK_PER=1 gives 512 on / 512 off with duty 0xFF
    wr(A_CTRL, 32'h0);
    wr(A_BLINK_PER, 32'h1);
    wr(A_BLINK_MASK, 32'h1);
    wr(A_DUTY0, 32'hFF);
    idle(4);
    wr(A_CTRL, 32'h3);
    clear_runs();
    idle(600);
    rd(A_STATUS, 32'h0001_0059, "blink_status");
    idle(2000);
    check("blink_npulses", 32'(hi_runs.size() >= 2), 32'd1);
    check("blink_on0", hi_runs[0], 32'd512);
    check("blink_on1", hi_runs[1], 32'd512);
    check("blink_off", lo_runs[1], 32'd512);

    // Prescaler: PRESC=3, then lowered below the running count
    wr(A_BLINK_MASK, 32'h0);
    wr(A_PRESC, 32'h3);
    wr(A_CTRL, 32'h3);
    idle(40);
    rd(A_STATUS, 32'hA, "presc3_status");
    idle(3);
    wr(A_PRESC, 32'h0);
    idle(10);
    rd(A_STATUS, 32'h15, "presc_lowered");

    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
